// File: rtl/spram_pkg.sv
// spram_pkg: shared constants and types for the single-port RAM responder.
//   - default geometry (AW/DW/DEPTH)
//   - write-collision mode encodings for the WR_MODE parameter
//   - controller state encoding
package spram_pkg;

  localparam int SPRAM_AW    = 5;
  localparam int SPRAM_DW    = 8;
  localparam int SPRAM_DEPTH = 32;

  // WR_MODE encodings: what the read port shows on a write access
  localparam int WRITE_FIRST = 0;  // new write data
  localparam int READ_FIRST  = 1;  // previous contents of the word
  localparam int NO_CHANGE   = 2;  // read port holds

  typedef enum logic {
    ST_INIT = 1'b0,  // post-reset zero-fill sweep
    ST_RUN  = 1'b1   // serving accesses
  } spram_state_e;

endpackage

// File: rtl/spram_rd_pipe.sv
// spram_rd_pipe: RD_LAT-deep read-data/valid delay line.
//   clk, rst_n  : clock, async active-low reset (clears every stage)
//   in_ld       : stage-1 data register loads in_data (otherwise holds)
//   in_vld      : read-valid entering the pipe
//   in_data     : word from the array read or write-mode bypass
//   out_vld     : valid after RD_LAT cycles
//   out_data    : data after RD_LAT cycles
module spram_rd_pipe #(
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_ld,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data
);

  logic [RD_LAT:1]         vld_pipe;
  logic [RD_LAT:1][DW-1:0] data_pipe;

  // Only stage 1 has a hold condition. Later stages copy every cycle, so they
  // replay stage 1's held value and the output still holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      if (in_ld) data_pipe[1] <= in_data;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[RD_LAT];
  assign out_data = data_pipe[RD_LAT];

endmodule

// File: rtl/spram_rsp.sv
// spram_rsp: single-port RAM responder, behavioural stand-in for a vendor BRAM.
//   clk, rst_n     : clock, async active-low reset
//   ram_en         : access enable, sampled at posedge
//   ram_wr_H_rd_L  : 1 = write, 0 = read
//   ram_addr       : word address (AW bits)
//   ram_wr_data    : write data (DW bits)
//   ram_rd_data    : read data, RD_LAT cycles after the access; holds otherwise
//   rd_valid       : strobe aligned with data returned by a read
//   init_done      : high once the post-reset zero-fill has completed
//   addr_err       : strobe one cycle after an access with ram_addr >= DEPTH
//   wr_cnt, rd_cnt : saturating counts of accepted writes / reads
module spram_rsp
  import spram_pkg::*;
#(
  parameter int AW      = SPRAM_AW,
  parameter int DW      = SPRAM_DW,
  parameter int DEPTH   = SPRAM_DEPTH,
  parameter int RD_LAT  = 1,
  parameter int WR_MODE = WRITE_FIRST,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ram_en,
  input  logic          ram_wr_H_rd_L,
  input  logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_wr_data,
  output logic [DW-1:0] ram_rd_data,
  output logic          rd_valid,
  output logic          init_done,
  output logic          addr_err,
  output logic [CW-1:0] wr_cnt,
  output logic [CW-1:0] rd_cnt
);

  logic [DW-1:0] mem [DEPTH];

  spram_state_e  state_q, state_d;
  logic [AW-1:0] ptr_q;

  logic          in_range, acc, wr_acc, rd_acc;
  logic [DW-1:0] mem_rd;
  logic          pipe_ld, pipe_vld;
  logic [DW-1:0] pipe_data;

  // One extra bit so DEPTH == 2^AW compares correctly.
  assign in_range = {1'b0, ram_addr} < (AW+1)'(DEPTH);
  assign acc      = (state_q == ST_RUN) && ram_en;
  assign wr_acc   = acc &&  ram_wr_H_rd_L;
  assign rd_acc   = acc && !ram_wr_H_rd_L;
  // Out-of-range addresses are masked below, never consumed.
  assign mem_rd   = mem[ram_addr];

  // ---------------- controller FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) ptr_q <= ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (ptr_q == AW'(DEPTH-1)) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign init_done = (state_q == ST_RUN);

  // ---------------- array ----------------
  // No reset on the array itself; the INIT sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT)       mem[ptr_q]    <= '0;
    else if (wr_acc && in_range)  mem[ram_addr] <= ram_wr_data;
  end

  // ---------------- read-port source ----------------
  // Reads always produce data (zero when out of range). Writes only feed the
  // read port in write-first / read-first modes, and never assert valid.
  always_comb begin
    pipe_ld   = 1'b0;
    pipe_vld  = 1'b0;
    pipe_data = '0;
    if (rd_acc) begin
      pipe_ld   = 1'b1;
      pipe_vld  = 1'b1;
      pipe_data = in_range ? mem_rd : '0;
    end else if (wr_acc && in_range) begin
      case (WR_MODE)
        WRITE_FIRST: begin pipe_ld = 1'b1; pipe_data = ram_wr_data; end
        READ_FIRST:  begin pipe_ld = 1'b1; pipe_data = mem_rd;      end
        default:     pipe_ld = 1'b0;
      endcase
    end
  end

  spram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_ld    (pipe_ld),
    .in_vld   (pipe_vld),
    .in_data  (pipe_data),
    .out_vld  (rd_valid),
    .out_data (ram_rd_data)
  );

  // ---------------- range error + counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
    end else begin
      addr_err <= acc && !in_range;
      if (wr_acc && (wr_cnt != '1)) wr_cnt <= wr_cnt + 1'b1;
      if (rd_acc && (rd_cnt != '1)) rd_cnt <= rd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spram_rsp.sv
// tb_spram_rsp: three spram_rsp configurations share one random/directed
// stimulus stream. Each has a transaction-level model (plain array + queues of
// expected read-port events) updated at the sampling edge; a monitor on the
// falling edge pops due events and compares every output.
//   cfg0: DEPTH=32 RD_LAT=1 WRITE_FIRST CW=16
//   cfg1: DEPTH=20 RD_LAT=2 READ_FIRST  CW=16
//   cfg2: DEPTH=32 RD_LAT=2 NO_CHANGE   CW=4 (saturates)
module tb_spram_rsp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       started = 1'b0;
  logic       ram_en = 1'b0;
  logic       ram_wr_H_rd_L = 1'b0;
  logic [4:0] ram_addr = '0;
  logic [7:0] ram_wr_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       vld;
    logic [7:0] d;
  } ev_t;

  task automatic chk(input int id, input string nm, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h (t=%0t)", id, nm, act, exp_v, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int D    = (g == 1) ? 20 : 32;
    localparam int L    = (g == 0) ? 1 : 2;
    localparam int WM   = g;
    localparam int CWI  = (g == 2) ? 4 : 16;
    localparam int MAXC = (1 << CWI) - 1;

    logic [7:0]     rd_data;
    logic           rd_valid, init_done, addr_err;
    logic [CWI-1:0] wr_cnt, rd_cnt;

    spram_rsp #(.AW(5), .DW(8), .DEPTH(D), .RD_LAT(L), .WR_MODE(WM), .CW(CWI)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ram_en        (ram_en),
      .ram_wr_H_rd_L (ram_wr_H_rd_L),
      .ram_addr      (ram_addr),
      .ram_wr_data   (ram_wr_data),
      .ram_rd_data   (rd_data),
      .rd_valid      (rd_valid),
      .init_done     (init_done),
      .addr_err      (addr_err),
      .wr_cnt        (wr_cnt),
      .rd_cnt        (rd_cnt)
    );

    // ---- reference model ----
    logic [7:0] m [32];
    int         init_left = D;
    int         wc = 0, rc = 0, mcyc = 0;
    ev_t        q[$];
    int         eq[$];

    always @(posedge clk or negedge rst_n) begin : model
      logic       inr;
      logic [7:0] old;
      if (!rst_n) begin
        init_left = D;
        wc = 0;
        rc = 0;
        q.delete();
        eq.delete();
        foreach (m[i]) m[i] = 8'h00;
      end else begin
        mcyc++;
        if (init_left > 0) init_left--;
        else if (ram_en) begin
          inr = (int'(ram_addr) < D);
          if (ram_wr_H_rd_L) begin
            if (wc < MAXC) wc++;
            if (inr) begin
              old = m[ram_addr];
              m[ram_addr] = ram_wr_data;
              if (WM == 0)      q.push_back('{mcyc + L - 1, 1'b0, ram_wr_data});
              else if (WM == 1) q.push_back('{mcyc + L - 1, 1'b0, old});
            end
          end else begin
            if (rc < MAXC) rc++;
            q.push_back('{mcyc + L - 1, 1'b1, inr ? m[ram_addr] : 8'h00});
          end
          if (!inr) eq.push_back(mcyc);
        end
      end
    end

    // ---- monitor / scoreboard ----
    logic [7:0] exp_d = 8'h00;

    always @(negedge clk) begin : mon
      ev_t  e;
      logic vld_e, err_e;
      if (started) begin
        if (!rst_n) begin
          exp_d = 8'h00;
          chk(g, "reset rd_data",   rd_data,   0);
          chk(g, "reset rd_valid",  rd_valid,  0);
          chk(g, "reset init_done", init_done, 0);
          chk(g, "reset addr_err",  addr_err,  0);
          chk(g, "reset wr_cnt",    wr_cnt,    0);
          chk(g, "reset rd_cnt",    rd_cnt,    0);
        end else begin
          vld_e = 1'b0;
          if (q.size() > 0 && q[0].due == mcyc) begin
            e = q.pop_front();
            exp_d = e.d;
            vld_e = e.vld;
          end
          err_e = (eq.size() > 0 && eq[0] == mcyc);
          if (err_e) void'(eq.pop_front());
          chk(g, "rd_valid",  rd_valid,  vld_e);
          chk(g, "rd_data",   rd_data,   exp_d);
          chk(g, "addr_err",  addr_err,  err_e);
          chk(g, "init_done", init_done, (init_left == 0));
          chk(g, "wr_cnt",    wr_cnt,    wc);
          chk(g, "rd_cnt",    rd_cnt,    rc);
        end
      end
    end
  end

  // ---- stimulus ----
  task automatic drive(input logic en, input logic wr, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    ram_en        = en;
    ram_wr_H_rd_L = wr;
    ram_addr      = a;
    ram_wr_data   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic do_reset(input int hold);
    repeat (hold) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1;
    rst_n   = 1'b0;
    started = 1'b1;
    do_reset(3);

    // accesses while the zero-fill runs
    repeat (32)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    idle(2);

    // read back the whole array after init
    for (int a = 0; a < 32; a++) drive(1'b1, 1'b0, 5'(a), 8'h00);
    idle(3);

    // sequential fill then back-to-back readback
    for (int a = 0; a < 32; a++) drive(1'b1, 1'b1, 5'(a), 8'(a + 8'hA0));
    for (int a = 0; a < 32; a++) drive(1'b1, 1'b0, 5'(a), 8'h00);
    idle(3);

    // write collision on the same word, then read it
    drive(1'b1, 1'b1, 5'd5, 8'h11);
    drive(1'b1, 1'b1, 5'd5, 8'h22);
    idle(3);
    drive(1'b1, 1'b0, 5'd5, 8'h00);
    // out-of-range write then read at the same address
    drive(1'b1, 1'b1, 5'd25, 8'h55);
    drive(1'b1, 1'b0, 5'd25, 8'h00);
    idle(3);

    // random traffic, including read-after-write to the same word
    repeat (300)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    idle(3);

    // reset with reads in flight
    drive(1'b1, 1'b0, 5'd3, 8'h00);
    drive(1'b1, 1'b0, 5'd4, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b0;
    ram_en = 1'b0;
    do_reset(3);
    idle(34);
    for (int a = 0; a < 32; a++) drive(1'b1, 1'b0, 5'(a), 8'h00);
    idle(5);

    chk(0, "drain", g_cfg[0].q.size(), 0);
    chk(1, "drain", g_cfg[1].q.size(), 0);
    chk(2, "drain", g_cfg[2].q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
